// File: rtl/align_pkg.sv
// Shared types and defaults for the alignment datapath input stage.
package align_pkg;

    localparam int unsigned SEQ_LEN_DEFAULT = 32;
    localparam int unsigned BASE_W_DEFAULT  = 2;

    typedef logic [1:0] base_t;

    localparam base_t BASE_A = 2'b00;
    localparam base_t BASE_C = 2'b01;
    localparam base_t BASE_G = 2'b10;
    localparam base_t BASE_T = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_Q = 2'd1,
        LOAD_R = 2'd2,
        HOLD   = 2'd3
    } loader_state_e;

    function automatic int unsigned packed_width(input int unsigned len, input int unsigned base_w);
        return len * base_w;
    endfunction

endpackage

// File: rtl/seq_buffer.sv
// Packed sequence register: one base written per cycle at an index, async clear.
module seq_buffer
    import align_pkg::*;
#(
    parameter int unsigned SEQ_LEN = SEQ_LEN_DEFAULT,
    parameter int unsigned BASE_W  = BASE_W_DEFAULT,
    localparam int unsigned IDX_W  = $clog2(SEQ_LEN),
    localparam int unsigned DATA_W = packed_width(SEQ_LEN, BASE_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [BASE_W-1:0] wr_base,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] data_q;

    // Only the addressed slot changes; all other bases keep their previous value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            for (int unsigned i = 0; i < SEQ_LEN; i++) begin
                if (wr_en && (wr_idx == IDX_W'(i))) begin
                    data_q[i*BASE_W +: BASE_W] <= wr_base;
                end
            end
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/seq_loader.sv
// Serial-to-parallel loader: packs a query then a reference sequence, holds both until acked.
module seq_loader
    import align_pkg::*;
#(
    parameter int unsigned SEQ_LEN = SEQ_LEN_DEFAULT,
    parameter int unsigned BASE_W  = BASE_W_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      in_valid,
    input  logic [BASE_W-1:0]         in_base,
    output logic                      in_ready,
    output logic [SEQ_LEN*BASE_W-1:0] query_out,
    output logic [SEQ_LEN*BASE_W-1:0] ref_out,
    output logic                      load_done,
    output logic                      busy,
    input  logic                      array_ack
);

    localparam int unsigned IDX_W = $clog2(SEQ_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_LEN - 1);

    loader_state_e    state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             load_done_q, load_done_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             accept;
    logic             last_base;
    logic             q_wr_en;
    logic             r_wr_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            load_done_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            load_done_q <= load_done_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    // in_ready/busy are registered copies of the next-state decode, so in_valid never reaches in_ready.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        load_done_d = 1'b0;
        q_wr_en     = 1'b0;
        r_wr_en     = 1'b0;
        accept      = in_valid && in_ready_q;
        last_base   = (cnt_q == LAST_IDX);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_Q;
                    cnt_d   = '0;
                end
            end
            LOAD_Q: begin
                if (accept) begin
                    q_wr_en = 1'b1;
                    if (last_base) begin
                        state_d = LOAD_R;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            LOAD_R: begin
                if (accept) begin
                    r_wr_en = 1'b1;
                    if (last_base) begin
                        state_d     = HOLD;
                        cnt_d       = '0;
                        load_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            HOLD: begin
                if (array_ack) begin
                    state_d = start ? LOAD_Q : IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        in_ready_d = (state_d == LOAD_Q) || (state_d == LOAD_R);
        busy_d     = (state_d != IDLE);
    end

    seq_buffer #(
        .SEQ_LEN (SEQ_LEN),
        .BASE_W  (BASE_W)
    ) u_query_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (q_wr_en),
        .wr_idx  (cnt_q),
        .wr_base (in_base),
        .data_o  (query_out)
    );

    seq_buffer #(
        .SEQ_LEN (SEQ_LEN),
        .BASE_W  (BASE_W)
    ) u_ref_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (r_wr_en),
        .wr_idx  (cnt_q),
        .wr_base (in_base),
        .data_o  (ref_out)
    );

    assign in_ready  = in_ready_q;
    assign load_done = load_done_q;
    assign busy      = busy_q;

endmodule
